// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for the UART: first-word fall-through, occupancy flags,
// and a sticky overflow flag with a saturating count of bytes dropped while full.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned AFULL_LEVEL = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_stb,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_flush,
  input  logic                  i_ovf_clr,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [7:0]            o_data,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_afull,
  output logic                  o_full,
  output logic                  o_ovf,
  output logic [7:0]            o_drop_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_CNT = (DEPTH_LOG2+1)'(AFULL_LEVEL);

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_ovf;
  logic [7:0]            r_drop_cnt;

  logic w_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = w_valid & i_ready;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
  assign w_push  = i_wr_stb & (~w_full | w_pop);
  assign w_drop  = i_wr_stb & w_full & ~w_pop & ~i_flush;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear and drop in the same cycle: the drop wins over the old history.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_ovf_clr) begin
      r_ovf      <= w_drop;
      r_drop_cnt <= w_drop ? 8'h01 : 8'h00;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_wr_data;
  end

  assign o_valid    = w_valid;
  assign o_data     = w_valid ? r_mem[r_rptr] : '0;
  assign o_count    = r_count;
  assign o_afull    = (r_count >= AFULL_CNT);
  assign o_full     = w_full;
  assign o_ovf      = r_ovf;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios then random traffic, all checked
// against a queue-based model of the FIFO's occupancy and overflow rules.
module tb_uart_rx_fifo;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_wr_stb = 1'b0;
  logic [7:0] i_wr_data = '0;
  logic       i_flush = 1'b0;
  logic       i_ovf_clr = 1'b0;
  logic       i_ready = 1'b0;
  logic       o_valid;
  logic [7:0] o_data;
  logic [4:0] o_count;
  logic       o_afull;
  logic       o_full;
  logic       o_ovf;
  logic [7:0] o_drop_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  int         m_drop = 0;

  uart_rx_fifo #(.DEPTH_LOG2(4), .AFULL_LEVEL(12)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_wr_stb(i_wr_stb), .i_wr_data(i_wr_data),
    .i_flush(i_flush), .i_ovf_clr(i_ovf_clr), .o_valid(o_valid), .i_ready(i_ready),
    .o_data(o_data), .o_count(o_count), .o_afull(o_afull), .o_full(o_full),
    .o_ovf(o_ovf), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int n = mq.size();
    chk({tag, ".valid"}, 32'(o_valid), 32'(n != 0));
    chk({tag, ".data"},  32'(o_data),  (n != 0) ? 32'(mq[0]) : 32'h0);
    chk({tag, ".count"}, 32'(o_count), 32'(n));
    chk({tag, ".afull"}, 32'(o_afull), 32'(n >= 12));
    chk({tag, ".full"},  32'(o_full),  32'(n == 16));
    chk({tag, ".ovf"},   32'(o_ovf),   32'(m_ovf));
    chk({tag, ".drop"},  32'(o_drop_cnt), 32'(m_drop));
  endtask

  // Model: evaluated from the pre-edge model state and the applied inputs.
  task automatic model_edge();
    bit full = (mq.size() == 16);
    bit pop  = (mq.size() != 0) && i_ready;
    bit drop = 1'b0;
    if (i_flush) mq.delete();
    else begin
      drop = i_wr_stb && full && !pop;
      if (pop) void'(mq.pop_front());
      if (i_wr_stb && !drop) mq.push_back(i_wr_data);
    end
    if (i_ovf_clr) begin m_ovf = 1'b0; m_drop = 0; end
    if (drop) begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  task automatic step(input string tag, input bit stb, input logic [7:0] d,
                      input bit rdy, input bit fl, input bit clr);
    @(negedge i_clk);
    i_wr_stb = stb; i_wr_data = d; i_ready = rdy; i_flush = fl; i_ovf_clr = clr;
    @(posedge i_clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] last_rd;
    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    check_all("reset");
    @(negedge i_clk);
    i_rst = 1'b0;

    // Single byte, held then popped
    step("a5_push", 1, 8'hA5, 0, 0, 0);
    chk("a5_head", 32'(o_data), 32'hA5);
    chk("a5_cnt", 32'(o_count), 32'd1);
    for (int i = 0; i < 5; i++) step("a5_hold", 0, 8'h00, 0, 0, 0);
    chk("a5_held", 32'(o_data), 32'hA5);
    step("a5_pop", 0, 8'h00, 1, 0, 0);
    chk("a5_popped_data", 32'(o_data), 32'h0);
    chk("a5_popped_valid", 32'(o_valid), 32'h0);

    // Underflow attempt on empty FIFO
    step("underflow", 0, 8'h00, 1, 0, 0);
    chk("underflow_cnt", 32'(o_count), 32'd0);

    // Fill 16, watch flags, drain in order
    for (int i = 0; i < 16; i++) begin
      step("fill", 1, 8'(i), 0, 0, 0);
      if (i == 10) chk("afull_at11", 32'(o_afull), 32'd0);
      if (i == 11) chk("afull_at12", 32'(o_afull), 32'd1);
      if (i == 14) chk("full_at15", 32'(o_full), 32'd0);
    end
    chk("full_at16", 32'(o_full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(o_data), 32'(i));
      step("drain", 0, 8'h00, 1, 0, 0);
    end
    chk("drained_cnt", 32'(o_count), 32'd0);

    // Overflow drops at full, then clear
    for (int i = 0; i < 16; i++) step("refill", 1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 3; i++) step("ovf_push", 1, 8'hE0 + 8'(i), 0, 0, 0);
    chk("ovf_cnt", 32'(o_count), 32'd16);
    chk("ovf_flag", 32'(o_ovf), 32'd1);
    chk("ovf_drops", 32'(o_drop_cnt), 32'd3);
    chk("ovf_head", 32'(o_data), 32'h00);
    step("ovf_clr", 0, 8'h00, 0, 0, 1);
    chk("ovf_cleared", 32'(o_ovf), 32'd0);
    chk("drops_cleared", 32'(o_drop_cnt), 32'd0);

    // Push with simultaneous pop at full
    step("full_pushpop", 1, 8'h55, 1, 0, 0);
    chk("pushpop_cnt", 32'(o_count), 32'd16);
    chk("pushpop_ovf", 32'(o_ovf), 32'd0);
    last_rd = 8'h00;
    for (int i = 0; i < 16; i++) begin
      last_rd = o_data;
      step("drain2", 0, 8'h00, 1, 0, 0);
    end
    chk("last_read_55", 32'(last_rd), 32'h55);

    // Push and pop together at count 1
    step("one", 1, 8'h11, 0, 0, 0);
    step("one_pushpop", 1, 8'h22, 1, 0, 0);
    chk("one_pushpop_data", 32'(o_data), 32'h22);
    step("one_drain", 0, 8'h00, 1, 0, 0);

    // Flush with a same-cycle strobe, then saturating drops
    for (int i = 0; i < 5; i++) step("five", 1, 8'h30 + 8'(i), 0, 0, 0);
    step("flush_stb", 1, 8'h77, 1, 1, 0);
    chk("flush_cnt", 32'(o_count), 32'd0);
    chk("flush_valid", 32'(o_valid), 32'd0);
    for (int i = 0; i < 16; i++) step("sat_fill", 1, 8'(i), 0, 0, 0);
    for (int i = 0; i < 260; i++) step("sat_drop", 1, 8'hCC, 0, 0, 0);
    chk("drop_sat", 32'(o_drop_cnt), 32'hFF);
    step("flush_keep", 1, 8'h99, 0, 1, 0);
    chk("flush_keeps_ovf", 32'(o_ovf), 32'd1);
    chk("flush_keeps_drop", 32'(o_drop_cnt), 32'hFF);
    for (int i = 0; i < 16; i++) step("clrdrop_fill", 1, 8'(i), 0, 0, 0);
    step("clr_with_drop", 1, 8'hDD, 0, 0, 1);
    chk("clr_drop_ovf", 32'(o_ovf), 32'd1);
    chk("clr_drop_cnt", 32'(o_drop_cnt), 32'd1);
    step("flush_again", 0, 8'h00, 0, 1, 0);

    // Asynchronous reset at count 7
    for (int i = 0; i < 7; i++) step("pre_rst", 1, 8'h40 + 8'(i), 0, 0, 0);
    @(negedge i_clk);
    i_wr_stb = 1'b0; i_ready = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    mq.delete(); m_ovf = 1'b0; m_drop = 0;
    check_all("async_rst");
    @(negedge i_clk);
    i_rst = 1'b0;
    step("post_rst", 1, 8'h3C, 0, 0, 0);
    chk("post_rst_data", 32'(o_data), 32'h3C);
    chk("post_rst_cnt", 32'(o_count), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3));
    end

    @(negedge i_clk);
    i_wr_stb = 1'b0; i_ready = 1'b0; i_flush = 1'b0; i_ovf_clr = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
